// File: rtl/ps2_key_tracker.sv
// PS/2 key tracker: pops scan-code bytes from the receiver FIFO, strips the
// E0/F0 prefixes, tracks the single held key, drops typematic repeats and
// counts distinct presses for the seven-segment display.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for a byte at the FIFO head
//   S_RD   | pop strobe low; byte decoded on the closing edge
//   S_WAIT | pop strobe high; lets the FIFO settle its ready flag
module ps2_key_tracker #(
   parameter bit BCD_CNT = 1'b1
) (
   input  logic       clk_i,
   input  logic       resetn_i,
   input  logic       fifo_ready_i,
   input  logic [7:0] fifo_data_i,
   output logic       fifo_rd_n_o,
   output logic [7:0] key_code_o,
   output logic       key_ext_o,
   output logic       key_down_o,
   output logic [7:0] press_cnt_o,
   output logic       new_key_o,
   output logic       code_err_o
);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WAIT} state_t;

   state_t     state_q, state_d;
   logic       ext_q, ext_d;
   logic       brk_q, brk_d;
   logic [7:0] key_code_q, key_code_d;
   logic       key_ext_q, key_ext_d;
   logic       key_down_q, key_down_d;
   logic [7:0] press_cnt_q, press_cnt_d;
   logic       new_key_q, new_key_d;
   logic       code_err_q, code_err_d;
   logic [7:0] cnt_inc;
   logic       rd_active;
   logic       is_current;

   // State register.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) state_q <= S_IDLE;
      else           state_q <= state_d;
   end

   // Next-state: one byte per IDLE -> RD -> WAIT round trip.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (fifo_ready_i) state_d = S_RD;
         S_RD:    state_d = S_WAIT;
         S_WAIT:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs: pop strobe is a pure decode of state, so reset lifts it at once.
   always_comb begin
      rd_active   = (state_q == S_RD);
      fifo_rd_n_o = ~rd_active;
   end

   assign is_current = key_down_q && (fifo_data_i == key_code_q) && (ext_q == key_ext_q);

   // Next press count, wrapping 99 -> 00 in BCD or 255 -> 0 in binary.
   always_comb begin
      cnt_inc = press_cnt_q + 8'd1;
      if (BCD_CNT) begin
         if (press_cnt_q[3:0] == 4'd9) begin
            cnt_inc[3:0] = 4'd0;
            cnt_inc[7:4] = (press_cnt_q[7:4] == 4'd9) ? 4'd0 : press_cnt_q[7:4] + 4'd1;
         end else begin
            cnt_inc = {press_cnt_q[7:4], press_cnt_q[3:0] + 4'd1};
         end
      end
   end

   // Byte decode applied on the closing edge of RD.
   always_comb begin
      ext_d       = ext_q;
      brk_d       = brk_q;
      key_code_d  = key_code_q;
      key_ext_d   = key_ext_q;
      key_down_d  = key_down_q;
      press_cnt_d = press_cnt_q;
      new_key_d   = 1'b0;
      code_err_d  = 1'b0;
      if (rd_active) begin
         case (fifo_data_i)
            8'hE0: ext_d = 1'b1;
            8'hF0: brk_d = 1'b1;
            8'h00, 8'hFF: begin
               ext_d      = 1'b0;
               brk_d      = 1'b0;
               code_err_d = 1'b1;
            end
            default: begin
               ext_d = 1'b0;
               brk_d = 1'b0;
               if (brk_q) begin
                  // Releases of keys other than the tracked one are dropped.
                  if (is_current) key_down_d = 1'b0;
               end else if (!is_current) begin
                  key_code_d  = fifo_data_i;
                  key_ext_d   = ext_q;
                  key_down_d  = 1'b1;
                  press_cnt_d = cnt_inc;
                  new_key_d   = 1'b1;
               end
            end
         endcase
      end
   end

   // Datapath registers.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         ext_q       <= 1'b0;
         brk_q       <= 1'b0;
         key_code_q  <= 8'h00;
         key_ext_q   <= 1'b0;
         key_down_q  <= 1'b0;
         press_cnt_q <= 8'h00;
         new_key_q   <= 1'b0;
         code_err_q  <= 1'b0;
      end else begin
         ext_q       <= ext_d;
         brk_q       <= brk_d;
         key_code_q  <= key_code_d;
         key_ext_q   <= key_ext_d;
         key_down_q  <= key_down_d;
         press_cnt_q <= press_cnt_d;
         new_key_q   <= new_key_d;
         code_err_q  <= code_err_d;
      end
   end

   assign key_code_o  = key_code_q;
   assign key_ext_o   = key_ext_q;
   assign key_down_o  = key_down_q;
   assign press_cnt_o = press_cnt_q;
   assign new_key_o   = new_key_q;
   assign code_err_o  = code_err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: one BCD and one binary instance fed
// from the same FIFO stimulus.
module tb_ps2_key_tracker;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       fifo_ready = 1'b0;
   logic [7:0] fifo_data = 8'h00;

   logic       a_rd_n, a_ext, a_down, a_nk, a_err;
   logic [7:0] a_code, a_cnt;
   logic       b_rd_n, b_ext, b_down, b_nk, b_err;
   logic [7:0] b_code, b_cnt;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int rd_cnt = 0;
   int last_rd = -1;
   int gap_bad = 0;
   int nk_cnt = 0;

   ps2_key_tracker #(.BCD_CNT(1'b1)) u_bcd (
      .clk_i(clk), .resetn_i(resetn), .fifo_ready_i(fifo_ready), .fifo_data_i(fifo_data),
      .fifo_rd_n_o(a_rd_n), .key_code_o(a_code), .key_ext_o(a_ext), .key_down_o(a_down),
      .press_cnt_o(a_cnt), .new_key_o(a_nk), .code_err_o(a_err));

   ps2_key_tracker #(.BCD_CNT(1'b0)) u_bin (
      .clk_i(clk), .resetn_i(resetn), .fifo_ready_i(fifo_ready), .fifo_data_i(fifo_data),
      .fifo_rd_n_o(b_rd_n), .key_code_o(b_code), .key_ext_o(b_ext), .key_down_o(b_down),
      .press_cnt_o(b_cnt), .new_key_o(b_nk), .code_err_o(b_err));

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Pop strobe spacing and new_key pulse counting.
   always @(negedge clk) begin
      if (!a_rd_n) begin
         if (last_rd >= 0 && cyc - last_rd != 3) gap_bad++;
         last_rd = cyc;
         rd_cnt++;
      end
      if (a_nk) nk_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clr_mon();
      @(posedge clk); #1;
      rd_cnt = 0; last_rd = -1; gap_bad = 0; nk_cnt = 0;
   endtask

   task automatic do_reset();
      @(negedge clk); #2;
      resetn = 1'b0;
      #1;
      chk("rst_rd_n", {a_rd_n, b_rd_n}, 2'b11);
      chk("rst_code", a_code, 8'h00);
      chk("rst_flags", {a_ext, a_down, a_nk, a_err}, 4'b0000);
      chk("rst_cnt", {a_cnt, b_cnt}, 16'h0000);
      @(negedge clk);
      resetn = 1'b1;
      clr_mon();
   endtask

   // Present one byte; returns at the negedge of WAIT with results visible.
   task automatic send_byte(input logic [7:0] b);
      bit seen = 1'b0;
      @(negedge clk);
      fifo_ready = 1'b1;
      fifo_data  = b;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(posedge clk); #1;
         if (!a_rd_n) seen = 1'b1;
      end
      if (!seen) chk("rd_timeout", 32'd0, 32'd1);
      @(negedge clk);
      @(negedge clk);
      fifo_ready = 1'b0;
   endtask

   initial begin
      #23 resetn = 1'b1;
      repeat (3) @(negedge clk);

      // Reset mid-idle, then press and release A.
      do_reset();
      send_byte(8'h1C);
      chk("a_nk", a_nk, 1'b1);
      chk("a_code", a_code, 8'h1C);
      chk("a_down", a_down, 1'b1);
      chk("a_cnt", {a_cnt, b_cnt}, 16'h0101);
      @(negedge clk);
      chk("a_nk_one", a_nk, 1'b0);
      send_byte(8'hF0);
      chk("a_f0_hold", a_down, 1'b1);
      send_byte(8'h1C);
      chk("a_rel_down", a_down, 1'b0);
      chk("a_rel_code", a_code, 8'h1C);
      chk("a_rel_cnt", a_cnt, 8'h01);

      // Typematic repeat.
      do_reset();
      for (int i = 0; i < 5; i++) send_byte(8'h1C);
      @(posedge clk); #1;
      chk("tm_rd5", rd_cnt, 32'd5);
      chk("tm_gap", gap_bad, 32'd0);
      chk("tm_nk", nk_cnt, 32'd1);
      chk("tm_cnt", a_cnt, 8'h01);
      send_byte(8'hF0);
      send_byte(8'h1C);
      chk("tm_rel", a_down, 1'b0);
      chk("tm_cnt2", a_cnt, 8'h01);

      // Extended key versus plain key.
      do_reset();
      send_byte(8'hE0);
      chk("ex_e0", {a_down, a_nk}, 2'b00);
      send_byte(8'h75);
      chk("ex_key", {a_ext, a_code, a_cnt}, {1'b1, 8'h75, 8'h01});
      send_byte(8'h75);
      chk("ex_plain", {a_ext, a_code, a_cnt, a_nk}, {1'b0, 8'h75, 8'h02, 1'b1});
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h75);
      chk("ex_rel_ign", {a_down, a_ext, a_cnt}, {1'b1, 1'b0, 8'h02});

      // Rollover.
      do_reset();
      send_byte(8'h1C);
      send_byte(8'h1B);
      chk("ro_code", {a_code, a_cnt}, {8'h1B, 8'h02});
      send_byte(8'hF0);
      send_byte(8'h1C);
      chk("ro_old_rel", {a_down, a_code}, {1'b1, 8'h1B});
      send_byte(8'hF0);
      send_byte(8'h1B);
      chk("ro_new_rel", a_down, 1'b0);

      // Error byte: flags cleared, key state kept.
      do_reset();
      send_byte(8'h1C);
      send_byte(8'hFF);
      chk("err_pulse", {a_err, b_err}, 2'b11);
      chk("err_keep", {a_down, a_code, a_cnt}, {1'b1, 8'h1C, 8'h01});
      @(negedge clk);
      chk("err_one", a_err, 1'b0);
      send_byte(8'hE0);
      send_byte(8'h00);
      send_byte(8'h1C);
      chk("err_clr_ext", {a_ext, a_cnt, a_nk}, {1'b0, 8'h01, 1'b0});

      // Reset while in RD.
      @(negedge clk);
      fifo_ready = 1'b1;
      fifo_data  = 8'h2A;
      @(posedge clk); #1;
      chk("rdrst_low", a_rd_n, 1'b0);
      #2 resetn = 1'b0;
      #1;
      chk("rdrst_high", {a_rd_n, b_rd_n}, 2'b11);
      chk("rdrst_state", {a_down, a_cnt}, {1'b0, 8'h00});
      fifo_ready = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      clr_mon();
      repeat (4) @(negedge clk);
      chk("rdrst_idle", rd_cnt, 32'd0);
      send_byte(8'h1C);
      chk("rdrst_after", {a_code, a_cnt}, {8'h1C, 8'h01});

      // Counter wrap: alternating makes, each one a distinct press.
      do_reset();
      for (int i = 1; i <= 256; i++) begin
         send_byte((i % 2 == 1) ? 8'h1C : 8'h1B);
         if (i == 9)   chk("bcd_09", a_cnt, 8'h09);
         if (i == 10)  chk("bcd_10", a_cnt, 8'h10);
         if (i == 99)  chk("bcd_99", a_cnt, 8'h99);
         if (i == 100) chk("bcd_00", {a_cnt, b_cnt}, {8'h00, 8'h64});
         if (i == 255) chk("bin_ff", b_cnt, 8'hFF);
         if (i == 256) chk("bin_00", {b_cnt, a_cnt}, {8'h00, 8'h56});
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
